spi_ram_arbiter: RTL
====================

Name: spi_ram_arbiter

Overview:
Sequencer and two-port arbiter for the SPI-slave single-port RAM. It accepts byte read and write requests from two independent requesters and grants one at a time using round-robin priority. It expands each request into the RAM's 10-bit command words: 00 write address, 01 write data, 10 read address, 11 read data. For reads it waits for the RAM's tx_valid/dout response, bounded by a timeout. It sits between the requesters and the RAM's rx_valid/din/tx_valid/dout interface.

Parameters:
TIMEOUT, 4, maximum number of RD_WAIT cycles before a read aborts; legal range 1..255.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
req0  in  1  requester 0 request; hold high until gnt0
we0  in  1  requester 0 op: 1 = write, 0 = read
addr0  in  8  requester 0 RAM address
wdata0  in  8  requester 0 write byte
gnt0  out  1  one-cycle pulse; requester 0 op accepted and latched
done0  out  1  one-cycle pulse; requester 0 op finished
err0  out  1  one-cycle pulse with done0; read timed out
rdata0  out  8  requester 0 read byte; valid from done0, held until next successful read for port 0
req1, we1, addr1, wdata1, gnt1, done1, err1, rdata1  same as port 0, for requester 1
ram_din  out  10  command word: [9:8] command, [7:0] payload
ram_rx_valid  out  1  ram_din valid strobe
ram_tx_valid  in  1  RAM read-data valid
ram_dout  in  8  RAM read data
busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. busy is decoded from the state register.
- Reset (async, rst=1): state=IDLE; rr_ptr=0 (port 0 has priority); every output 0, including rdata0/1 and ram_din. Reset mid-transaction aborts immediately, with no done or err.
- States: IDLE, CMD1, CMD2, RD_WAIT, DONE.
- IDLE, arbitration:
  - req is sampled only in IDLE.
  - If only one req is high, that port wins. If both are high, the port selected by rr_ptr wins, and rr_ptr then points at the other port.
  - If only one port requests, rr_ptr is set to the other port after the grant.
  - At the winning edge: latch port id, we, addr and wdata; pulse gnt for 1 cycle; drive ram_din={we?00:10, addr} with ram_rx_valid=1; go to CMD1.
- CMD1 → CMD2: drive ram_din={01, wdata} for a write or {11, 8'h00} for a read; ram_rx_valid=1.
- CMD2: ram_rx_valid=0. A write goes to DONE. A read goes to RD_WAIT and clears the wait counter.
- RD_WAIT:
  - If ram_tx_valid=1: capture ram_dout into rdata of the latched port; go to DONE with done pulse.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no tx_valid: go to DONE with done and err pulses; rdata is unchanged.
- DONE: done (and err if flagged) is high this cycle; next state is IDLE.
- ram_rx_valid is high in exactly the 2 cycles per transaction when ram_din carries a command. ram_din holds its last value otherwise.
- ram_tx_valid outside RD_WAIT is ignored.
- Changes on req, we, addr or wdata after gnt have no effect on the running transaction.
- A req still high when the block returns to IDLE is treated as a new request. Requesters drop req on seeing gnt.
- Latency, req high at edge 0:
  - gnt and first command at cycle 1, second command at cycle 2.
  - Write: done at cycle 3.
  - Read, with the RAM answering 1 cycle after the 11 command: tx_valid at cycle 3, done and rdata at cycle 4.
  - The block returns to IDLE one cycle after done.
- Simultaneous events:
  - req arriving while busy waits, and is arbitrated on the next IDLE cycle.
  - Both reqs arriving in the same IDLE cycle are resolved by rr_ptr only.

Test Plan:
- Reset then write: req0=1, we0=1, addr0=8'h3C, wdata0=8'hA5 → gnt0 cycle 1 with ram_din=10'h03C and rx_valid=1; cycle 2 ram_din=10'h1A5; done0 cycle 3; err0=0; no gnt1 or done1.
- Read hit: RAM model returns ram_dout=8'h5A with tx_valid one cycle after command 11 for addr1=8'h10 → ram_din sequence 10'h210 then 10'h300; done1=1 with rdata1=8'h5A; err1=0.
- Contention: req0 and req1 both held continuously from reset → grants alternate 0,1,0,1, starting with 0; no port is granted twice in a row.
- Timeout: read with ram_tx_valid tied 0, TIMEOUT=4 → exactly 4 RD_WAIT cycles, then done0=1 and err0=1 in the same cycle; rdata0 keeps its previous value.
- Reset mid-read: assert rst during RD_WAIT → busy, ram_rx_valid and rdata clear immediately; no done or err pulse; the next request after reset is served normally from port 0 priority.
- Stray tx_valid: pulse ram_tx_valid while IDLE and during a write → no rdata change, no done, FSM sequence unaffected.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter and command sequencer between two byte requesters and the
// SPI-slave single-port RAM command interface (rx_valid/din, tx_valid/dout).
module spi_ram_arbiter #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       gnt0,
  output logic       done0,
  output logic       err0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       gnt1,
  output logic       done1,
  output logic       err1,
  output logic [7:0] rdata1,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic       ram_tx_valid,
  input  logic [7:0] ram_dout,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, CMD1, CMD2, RD_WAIT, DONE} state_t;

  state_t     state;
  logic       rr_ptr;
  logic       port;
  logic       op_we;
  logic [7:0] op_wdata;
  logic [7:0] cnt;

  // rr_ptr only breaks ties; a lone requester always wins
  logic       win;
  logic       sel_we;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;

  assign win       = (req0 && req1) ? rr_ptr : req1;
  assign sel_we    = win ? we1 : we0;
  assign sel_addr  = win ? addr1 : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      port         <= 1'b0;
      op_we        <= 1'b0;
      op_wdata     <= 8'h00;
      cnt          <= 8'h00;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata0       <= 8'h00;
      rdata1       <= 8'h00;
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
    end else begin
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      ram_rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            port         <= win;
            op_we        <= sel_we;
            op_wdata     <= sel_wdata;
            rr_ptr       <= ~win;
            gnt0         <= ~win;
            gnt1         <= win;
            ram_din      <= {~sel_we, 1'b0, sel_addr};
            ram_rx_valid <= 1'b1;
            state        <= CMD1;
          end
        end
        CMD1: begin
          ram_din      <= op_we ? {2'b01, op_wdata} : {2'b11, 8'h00};
          ram_rx_valid <= 1'b1;
          state        <= CMD2;
        end
        CMD2: begin
          if (op_we) begin
            done0 <= ~port;
            done1 <= port;
            state <= DONE;
          end else begin
            cnt   <= 8'h00;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (ram_tx_valid) begin
            if (port) rdata1 <= ram_dout;
            else      rdata0 <= ram_dout;
            done0 <= ~port;
            done1 <= port;
            state <= DONE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            done0 <= ~port;
            done1 <= port;
            err0  <= ~port;
            err1  <= port;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
